frame_fifo_wr_arb: RTL and testbench

Write-side arbiter for the frame FIFO's write port, which is a valid/ready style port (wr_data, wr_en, wr_vld).
- Shares the port between NUM_REQ pixel producers (e.g. CPU framebuffer writer, sprite/DMA engine) using round-robin, burst-locked grants.
- Guarantees that no producer's burst is interleaved with another's.
- Guarantees that no beat is dropped or duplicated when the FIFO backpressures.
- Sits between the producers and the frame FIFO, in the FIFO's write clock domain.

---
 rtl/frame_fifo_wr_arb_pkg.sv | 24 ++
 rtl/frame_fifo_wr_arb_if.sv | 36 +++
 rtl/rr_arb_pick.sv | 47 ++++
 rtl/frame_fifo_wr_arb.sv | 125 ++++++++++++
 tb/tb_frame_fifo_wr_arb.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_fifo_wr_arb_pkg.sv
// Shared definitions for the frame FIFO write arbiter and its pickers:
// FSM state encoding, default burst length and a width helper.
package frame_fifo_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  // Default number of beats a single grant may carry before forced release.
  localparam int DEF_MAX_BURST = 16;

  // Ceiling log2, used for derived counter and index widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_fifo_wr_arb_if.sv
// Producer-side and FIFO-side handshake bundle of the write arbiter.
// The arbiter uses the slave view; producers/FIFO (or a bench) use master.
interface frame_fifo_wr_arb_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_wr_en;
  logic                          fifo_wr_vld;

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  fifo_wr_vld,
    output req_ready,
    output fifo_wr_data,
    output fifo_wr_en
  );

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    output fifo_wr_vld,
    input  req_ready,
    input  fifo_wr_data,
    input  fifo_wr_en
  );

endinterface

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: returns the first requester found when
// scanning ptr, ptr+1, ... modulo N, as a one-hot vector and an index.
// Shared with the read-side scheduler.
module rr_arb_pick
  import frame_fifo_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx
);

  // Candidate index for scan position gi, and whether it is requesting.
  logic [IDX_W-1:0] cand_idx [N];
  logic [N-1:0]     cand_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [IDX_W:0] cand_sum;
      // Wrap by comparison so non-power-of-two N works.
      assign cand_sum     = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign cand_idx[gi] = (cand_sum >= (IDX_W+1)'(N))
                            ? IDX_W'(cand_sum - (IDX_W+1)'(N))
                            : IDX_W'(cand_sum);
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // Earliest scan position with a request wins.
  always_comb begin
    grant_idx = '0;
    grant_oh  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        grant_idx = cand_idx[k];
      end
    end
    if (|cand_hit) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/frame_fifo_wr_arb.sv
// Write-side arbiter for the frame FIFO: round-robin, burst-locked sharing
// of the FIFO write port among NUM_REQ pixel producers. One idle cycle per
// grant; during a burst the granted producer is passed straight through.
module frame_fifo_wr_arb
  import frame_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int CNT_W      = clog2(MAX_BURST + 1),
  parameter int ID_W       = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arb_en,
  frame_fifo_wr_arb_if.slave   bus,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic [CNT_W-1:0]     beat_cnt
);

  arb_state_t       state_reg;
  logic [ID_W-1:0]  rr_ptr_reg;
  logic [ID_W-1:0]  grant_id_reg;
  logic [CNT_W-1:0] beat_cnt_reg;
  logic             busy_reg;

  logic [NUM_REQ-1:0] pick_oh;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;

  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    ready_next;

  logic            in_burst;
  logic            sel_valid;
  logic            sel_last;
  logic            beat_acc;
  logic            cnt_at_max;
  logic            release_now;
  logic [ID_W-1:0] ptr_next;

  // Unpack the flattened producer data bus.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_data_arr[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_arb_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_reg),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx)
  );

  assign pick_any = |pick_oh;

  assign in_burst    = (state_reg == ST_BURST);
  assign sel_valid   = bus.req_valid[grant_id_reg];
  assign sel_last    = bus.req_last[grant_id_reg];
  assign beat_acc    = in_burst & sel_valid & bus.fifo_wr_vld;
  assign cnt_at_max  = (beat_cnt_reg == CNT_W'(MAX_BURST - 1));
  assign release_now = beat_acc & (sel_last | cnt_at_max);
  // Next round-robin start: one past the granted producer, wrapped by compare.
  assign ptr_next    = (grant_id_reg == ID_W'(NUM_REQ - 1))
                       ? '0 : grant_id_reg + ID_W'(1);

  // Only the granted producer sees the FIFO's ready, and only in a burst.
  always_comb begin
    ready_next = '0;
    if (in_burst) begin
      ready_next[grant_id_reg] = bus.fifo_wr_vld;
    end
  end

  assign bus.req_ready    = ready_next;
  assign bus.fifo_wr_en   = in_burst & sel_valid;
  assign bus.fifo_wr_data = in_burst ? req_data_arr[grant_id_reg] : '0;

  assign busy     = busy_reg;
  assign grant_id = grant_id_reg;
  assign beat_cnt = beat_cnt_reg;

  // Grant FSM: arbitrate in IDLE, count accepted beats and release in BURST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      rr_ptr_reg   <= '0;
      grant_id_reg <= '0;
      beat_cnt_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (arb_en && pick_any) begin
            grant_id_reg <= pick_idx;
            beat_cnt_reg <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (beat_acc) begin
            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
          end
          if (release_now) begin
            rr_ptr_reg <= ptr_next;
            busy_reg   <= 1'b0;
            state_reg  <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_fifo_wr_arb.sv
// Self-checking bench for frame_fifo_wr_arb: producers are beat queues, the
// reference model applies the round-robin / burst-release rules each cycle.
module tb_frame_fifo_wr_arb;

  localparam int N     = 3;
  localparam int DW    = 32;
  localparam int MB    = 16;
  localparam int CW    = 5;
  localparam int IW    = 2;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          arb_en;
  logic          busy;
  logic [IW-1:0] grant_id;
  logic [CW-1:0] beat_cnt;

  frame_fifo_wr_arb_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  frame_fifo_wr_arb #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .arb_en   (arb_en),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  // Producer queues: {last, data}
  logic [DW:0] mem [N][DEPTH];
  int          head [N];
  int          tail [N];
  bit [N-1:0]  hold;

  // Reference model state
  bit m_busy;
  int m_g, m_cnt, m_ptr;

  int n_checks = 0;
  int n_fail   = 0;
  int bubble_pct = 0;
  int vld_pct    = 100;
  bit rst_drv    = 1'b1;
  bit arb_en_drv = 1'b1;
  int total_pushed = 0;
  int dut_beats    = 0;
  int seqno        = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_burst(input int id, input int len);
    for (int b = 0; b < len; b++) begin
      if (tail[id] < DEPTH) begin
        seqno++;
        mem[id][tail[id]] = {(b == len - 1), 8'(id), 24'(seqno)};
        tail[id]++;
        total_pushed++;
      end
    end
  endtask

  function automatic int pending();
    int p = 0;
    for (int i = 0; i < N; i++) p += tail[i] - head[i];
    return p;
  endfunction

  function automatic logic [DW:0] head_word(input int id);
    return (head[id] < tail[id]) ? mem[id][head[id]] : '0;
  endfunction

  // One clock cycle: drive at negedge, check, then advance the model.
  task automatic step();
    logic [N-1:0]  e_ready;
    logic [DW-1:0] e_data;
    logic          e_en;
    logic [DW:0]   w;
    int            idx;
    @(negedge clk);
    rst         = rst_drv;
    arb_en      = arb_en_drv;
    bus.fifo_wr_vld = ($urandom_range(99) < vld_pct);
    for (int i = 0; i < N; i++) begin
      if (!hold[i] && head[i] < tail[i] && $urandom_range(99) >= bubble_pct) hold[i] = 1'b1;
      w = head_word(i);
      bus.req_valid[i]           = hold[i];
      bus.req_last[i]            = hold[i] & w[DW];
      bus.req_data[i*DW +: DW]   = w[DW-1:0];
    end
    #1;
    if (rst) begin
      m_busy = 1'b0; m_g = 0; m_cnt = 0; m_ptr = 0;
    end
    e_ready = '0;
    e_en    = 1'b0;
    e_data  = '0;
    if (m_busy) begin
      w       = head_word(m_g);
      e_en    = hold[m_g];
      e_data  = w[DW-1:0];
      e_ready[m_g] = bus.fifo_wr_vld;
    end
    check("busy",         busy,             m_busy);
    check("grant_id",     grant_id,         m_g);
    check("beat_cnt",     beat_cnt,         m_cnt);
    check("fifo_wr_en",   bus.fifo_wr_en,   e_en);
    check("fifo_wr_data", bus.fifo_wr_data, e_data);
    check("req_ready",    bus.req_ready,    e_ready);
    if (!rst) begin
      if (bus.fifo_wr_en && bus.fifo_wr_vld) dut_beats++;
      if (!m_busy) begin
        if (arb_en && hold != 0) begin
          for (int k = N - 1; k >= 0; k--) begin
            idx = (m_ptr + k) % N;
            if (hold[idx]) m_g = idx;
          end
          m_cnt  = 0;
          m_busy = 1'b1;
        end
      end else if (hold[m_g] && bus.fifo_wr_vld) begin
        w = head_word(m_g);
        head[m_g]++;
        hold[m_g] = 1'b0;
        m_cnt++;
        if (w[DW] || m_cnt == MB) begin
          m_busy = 1'b0;
          m_ptr  = (m_g + 1) % N;
        end
      end
    end
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) step();
  endtask

  task automatic wait_cnt(input int cnt, input string tag);
    int i = 0;
    while (!(m_busy && m_cnt == cnt) && i < 60) begin
      step();
      i++;
    end
    check(tag, (i < 60), 1'b1);
  endtask

  task automatic drain(input int budget, input string tag);
    int i = 0;
    while (pending() != 0 && i < budget) begin
      step();
      i++;
    end
    check(tag, pending(), 0);
    run(3);
  endtask

  initial begin
    rst = 1'b1;
    arb_en = 1'b0;
    hold = '0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_wr_vld = 1'b0;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
    m_busy = 1'b0; m_g = 0; m_cnt = 0; m_ptr = 0;

    // Reset state
    run(3);
    rst_drv = 1'b0;
    run(2);

    // Single 4-beat burst from requester 0
    push_burst(0, 4);
    run(8);
    check("t1_cnt_after", beat_cnt, 4);

    // Alternating 3-beat bursts from requesters 0 and 1
    push_burst(0, 3); push_burst(0, 3);
    push_burst(1, 3); push_burst(1, 3);
    drain(60, "t2_drain");

    // 20-beat burst forced to split at MAX_BURST, requester 1 waiting
    push_burst(0, 20);
    push_burst(1, 3);
    drain(80, "t3_drain");

    // FIFO stall of 5 cycles mid-burst
    push_burst(0, 8);
    wait_cnt(2, "t4_wait");
    vld_pct = 0;
    run(5);
    check("t4_cnt_held", beat_cnt, 2);
    vld_pct = 100;
    drain(40, "t4_drain");

    // arb_en dropped during beat 2: burst completes, then no new grant
    push_burst(0, 4);
    push_burst(1, 4);
    wait_cnt(1, "t5_wait");
    arb_en_drv = 1'b0;
    run(10);
    check("t5_idle_busy", busy, 1'b0);
    arb_en_drv = 1'b1;
    drain(40, "t5_drain");

    // Reset mid-burst at beat_cnt 3
    push_burst(2, 8);
    wait_cnt(3, "t6_wait");
    push_burst(1, 4);
    rst_drv = 1'b1;
    step();
    check("t6_rst_en", bus.fifo_wr_en, 1'b0);
    rst_drv = 1'b0;
    drain(80, "t6_drain");

    // Randomized traffic
    bubble_pct = 25;
    vld_pct    = 70;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (tail[i] - head[i] < 8 && $urandom_range(99) < 15)
          push_burst(i, $urandom_range(24, 1));
      end
      arb_en_drv = ($urandom_range(99) < 90);
      step();
    end
    arb_en_drv = 1'b1;
    drain(4000, "rand_drain");
    check("beat_total", dut_beats, total_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
